// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg
//
// Purpose: shared definitions for the multiply/divide unit and the decode
// logic that drives it. Holds the op encodings seen on the `op` port, the
// sequencer state encoding, the iteration bound and small operand helpers.
//
// Contents:
//   mdu_op_e     - MULT / MULTU / DIV / DIVU encodings of the 2-bit op field
//   mdu_state_e  - sequencer states IDLE, CALC, SIGN, DONE
//   LAST_ITER    - index of the final shift/add or shift/subtract iteration
//   abs32        - two's-complement magnitude of a 32-bit value
//   op_is_signed - op treats its operands as signed
//   op_is_div    - op is a divide

package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_SIGN = 2'b10,
        ST_DONE = 2'b11
    } mdu_state_e;

    localparam logic [5:0] LAST_ITER = 6'd31;

    // 0x80000000 maps onto itself, which reads correctly as the unsigned
    // magnitude 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] value);
        return value[31] ? (32'd0 - value) : value;
    endfunction

    // Bit 0 of the op field clear selects the signed variants.
    function automatic logic op_is_signed(input logic [1:0] op_code);
        return ~op_code[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op_code);
        return op_code[1];
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit
//
// Purpose: multi-cycle integer multiply/divide unit holding the HI/LO
// registers. MULT/MULTU use a 32-iteration shift-add engine, DIV/DIVU a
// 32-iteration restoring divider. Every operation takes the same fixed
// latency: start sampled at the end of cycle 0, busy in cycles 1..33, HI/LO
// written at the end of cycle 33, done pulsed in cycle 34. MTHI/MTLO writes
// are accepted only while no operation is in flight.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous active-high reset
//   start        in   begin operation `op` on rs_data/rt_data
//   op[1:0]      in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_data[31:0] in  multiplicand / dividend
//   rt_data[31:0] in  multiplier / divisor
//   hi_we        in   MTHI write enable
//   lo_we        in   MTLO write enable
//   write_data[31:0] in MTHI/MTLO data
//   busy         out  operation in progress (registered)
//   done         out  one-cycle pulse, HI/LO valid (registered)
//   div_by_zero  out  last divide had a zero divisor, valid with done
//   hi[31:0]     out  HI register
//   lo[31:0]     out  LO register

module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] write_data,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e  state_q, state_d;
    logic [1:0]  op_q, op_d;
    // Multiplicand for multiplies, divisor for divides (always a magnitude).
    logic [31:0] operand_q, operand_d;
    // Multiply: {carry, product_hi, product_lo/multiplier}.
    // Divide:   {remainder[32:0], quotient/dividend}.
    logic [64:0] acc_q, acc_d;
    logic [5:0]  count_q, count_d;
    logic        neg_result_q, neg_result_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div_zero_q, div_zero_d;
    logic [31:0] dividend_q, dividend_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    // One iteration of each engine, computed from the current accumulator.
    logic [32:0] mul_upper;
    logic [64:0] mul_next;
    logic [32:0] div_shift;
    logic [33:0] div_trial;
    logic [64:0] div_next;

    // Result fix-up applied in the SIGN state.
    logic [63:0] product_mag;
    logic [63:0] product_final;
    logic [31:0] quot_final;
    logic [31:0] rem_final;

    // Operand preparation for an accepted start.
    logic        start_signed;
    logic        start_div;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;

    // Iteration datapath. The multiply adds the multiplicand into the upper
    // half when the multiplier LSB is set and shifts right, so the carry out
    // of the add lands in bit 63. The divide shifts {rem,quot} left and keeps
    // the trial subtraction only when it does not borrow.
    always_comb begin
        mul_upper = acc_q[64:32];
        if (acc_q[0]) begin
            mul_upper = acc_q[64:32] + {1'b0, operand_q};
        end
        mul_next = {1'b0, mul_upper, acc_q[31:1]};

        div_shift = {acc_q[63:32], acc_q[31]};
        div_trial = {1'b0, div_shift} - {2'b00, operand_q};
        if (!div_trial[33]) begin
            div_next = {div_trial[32:0], acc_q[30:0], 1'b1};
        end else begin
            div_next = {div_shift, acc_q[30:0], 1'b0};
        end
    end

    // Sign restoration of the finished magnitudes. The quotient takes the
    // XOR of the operand signs; the remainder follows the dividend.
    always_comb begin
        product_mag   = acc_q[63:0];
        product_final = neg_result_q ? (64'd0 - product_mag) : product_mag;
        quot_final    = neg_result_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem_final     = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    end

    // Operand magnitudes and sign flags for a start in IDLE or DONE.
    always_comb begin
        start_signed = op_is_signed(op);
        start_div    = op_is_div(op);
        rs_mag       = start_signed ? abs32(rs_data) : rs_data;
        rt_mag       = start_signed ? abs32(rt_data) : rt_data;
    end

    // Sequencer next-state and register updates.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        operand_d    = operand_q;
        acc_d        = acc_q;
        count_d      = count_q;
        neg_result_d = neg_result_q;
        neg_rem_d    = neg_rem_q;
        div_zero_d   = div_zero_q;
        dividend_d   = dividend_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        dbz_d        = dbz_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                // A start takes priority; any MTHI/MTLO in the same cycle is
                // dropped.
                if (start) begin
                    state_d      = ST_CALC;
                    busy_d       = 1'b1;
                    op_d         = op;
                    count_d      = 6'd0;
                    dividend_d   = rs_data;
                    neg_result_d = start_signed & (rs_data[31] ^ rt_data[31]);
                    neg_rem_d    = start_signed & start_div & rs_data[31];
                    div_zero_d   = start_div & (rt_data == 32'd0);
                    if (start_div) begin
                        operand_d = rt_mag;
                        acc_d     = {33'd0, rs_mag};
                    end else begin
                        operand_d = rs_mag;
                        acc_d     = {33'd0, rt_mag};
                    end
                end else begin
                    if (hi_we) begin
                        hi_d = write_data;
                    end
                    if (lo_we) begin
                        lo_d = write_data;
                    end
                end
            end

            ST_CALC: begin
                busy_d  = 1'b1;
                acc_d   = op_is_div(op_q) ? div_next : mul_next;
                count_d = count_q + 6'd1;
                if (count_q == LAST_ITER) begin
                    state_d = ST_SIGN;
                end
            end

            ST_SIGN: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                dbz_d   = div_zero_q;
                if (!op_is_div(op_q)) begin
                    hi_d = product_final[63:32];
                    lo_d = product_final[31:0];
                end else if (div_zero_q) begin
                    hi_d = dividend_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = rem_final;
                    lo_d = quot_final;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation without touching HI/LO
    // beyond clearing them.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= 2'b00;
            operand_q    <= 32'd0;
            acc_q        <= 65'd0;
            count_q      <= 6'd0;
            neg_result_q <= 1'b0;
            neg_rem_q    <= 1'b0;
            div_zero_q   <= 1'b0;
            dividend_q   <= 32'd0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dbz_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            operand_q    <= operand_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            neg_result_q <= neg_result_d;
            neg_rem_q    <= neg_rem_d;
            div_zero_q   <= div_zero_d;
            dividend_q   <= dividend_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            dbz_q        <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
